// File: rtl/ysyx_25040129_pkg.sv
// Shared ysyx_25040129 definitions: memory op codes, AXI response codes and
// arbiter state/owner encodings.
package ysyx_25040129_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_t;

  // Owner that a just-finished transaction in state s belonged to.
  function automatic owner_t owner_of(arb_state_t s);
    return (s == IFU_RD) ? OWNER_IFU : OWNER_LSU;
  endfunction

endpackage

// File: rtl/ysyx_25040129_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-lite arbiter.
// One outstanding transaction; grant held in the registered state only.
module ysyx_25040129_axi_arbiter
  import ysyx_25040129_pkg::*;
#(
  parameter bit LSU_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  // IFU read
  input  logic [31:0] ifu_araddr,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  input  logic [2:0]  ifu_arsize,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  // LSU read
  input  logic [31:0] lsu_araddr,
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  input  logic [2:0]  lsu_arsize,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,
  // LSU write
  input  logic [31:0] lsu_awaddr,
  input  logic        lsu_awvalid,
  output logic        lsu_awready,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  input  logic        lsu_wvalid,
  output logic        lsu_wready,
  output logic [1:0]  lsu_bresp,
  output logic        lsu_bvalid,
  input  logic        lsu_bready,
  // Slave side
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  output logic [2:0]  arsize,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  // Resetting last_owner to the opposite master makes LSU_FIRST decide the first tie.
  localparam owner_t RESET_OWNER = LSU_FIRST ? OWNER_IFU : OWNER_LSU;

  arb_state_t state, state_d;
  owner_t     last_owner;
  logic       txn_done;
  logic       lsu_wr_req;
  logic       lsu_req;
  logic       lsu_wins;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= RESET_OWNER;
    end else begin
      state <= state_d;
      if (txn_done) begin
        last_owner <= owner_of(state);
      end
    end
  end

  always_comb begin
    state_d    = state;
    txn_done   = 1'b0;
    lsu_wr_req = lsu_awvalid | lsu_wvalid;
    lsu_req    = lsu_wr_req | lsu_arvalid;
    lsu_wins   = lsu_req && (!ifu_arvalid || (last_owner == OWNER_IFU));
    unique case (state)
      IDLE: begin
        if (lsu_wins) begin
          state_d = lsu_wr_req ? LSU_WR : LSU_RD;
        end else if (ifu_arvalid) begin
          state_d = IFU_RD;
        end
      end
      IFU_RD: txn_done = rvalid && ifu_rready;
      LSU_RD: txn_done = rvalid && lsu_rready;
      LSU_WR: txn_done = bvalid && lsu_bready;
      default: state_d = IDLE;
    endcase
    if (txn_done) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    araddr      = '0;
    arsize      = '0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    awaddr      = '0;
    awvalid     = 1'b0;
    wdata       = '0;
    wstrb       = '0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    // Data/response buses are broadcast; only the owner's valid qualifies them.
    ifu_rdata   = rdata;
    ifu_rresp   = rresp;
    lsu_rdata   = rdata;
    lsu_rresp   = rresp;
    lsu_bresp   = bresp;
    unique case (state)
      IFU_RD: begin
        araddr      = ifu_araddr;
        arsize      = ifu_arsize;
        arvalid     = ifu_arvalid;
        ifu_arready = arready;
        ifu_rvalid  = rvalid;
        rready      = ifu_rready;
      end
      LSU_RD: begin
        araddr      = lsu_araddr;
        arsize      = lsu_arsize;
        arvalid     = lsu_arvalid;
        lsu_arready = arready;
        lsu_rvalid  = rvalid;
        rready      = lsu_rready;
      end
      LSU_WR: begin
        awaddr      = lsu_awaddr;
        awvalid     = lsu_awvalid;
        lsu_awready = awready;
        wdata       = lsu_wdata;
        wstrb       = lsu_wstrb;
        wvalid      = lsu_wvalid;
        lsu_wready  = wready;
        lsu_bvalid  = bvalid;
        bready      = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040129_axi_arbiter.sv
// Self-checking bench for the IFU/LSU AXI arbiter with a behavioural slave.
module tb_ysyx_25040129_axi_arbiter;
  import ysyx_25040129_pkg::*;

  localparam int BUDGET = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ifu_araddr = '0;
  logic        ifu_arvalid = 1'b0;
  logic        ifu_arready;
  logic [2:0]  ifu_arsize = 3'd2;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rready = 1'b0;
  logic [31:0] lsu_araddr = '0;
  logic        lsu_arvalid = 1'b0;
  logic        lsu_arready;
  logic [2:0]  lsu_arsize = 3'd2;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_rvalid;
  logic        lsu_rready = 1'b0;
  logic [31:0] lsu_awaddr = '0;
  logic        lsu_awvalid = 1'b0;
  logic        lsu_awready;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wstrb = '0;
  logic        lsu_wvalid = 1'b0;
  logic        lsu_wready;
  logic [1:0]  lsu_bresp;
  logic        lsu_bvalid;
  logic        lsu_bready = 1'b0;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [2:0]  arsize;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] data; logic [1:0] resp; } rd_exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; logic [1:0] resp; } wr_exp_t;
  rd_exp_t ifu_exp_q[$];
  rd_exp_t lsu_exp_q[$];
  wr_exp_t wr_exp_q[$];
  bit      order_q[$];   // 0 = IFU, 1 = LSU completion expected next

  ysyx_25040129_axi_arbiter #(.LSU_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_arsize(ifu_arsize),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_arsize(lsu_arsize),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arsize(arsize),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural slave ----------------
  logic        sl_clear = 1'b1;
  int          sl_lat = 3;
  int          sl_b_lat = 1;
  logic [31:0] sl_err_addr = 32'hffff_fff0;
  logic        r_busy = 1'b0;
  int          r_cnt = 0;
  logic [31:0] r_addr = '0;
  logic        aw_got = 1'b0;
  logic        w_got = 1'b0;
  int          b_cnt = 0;
  logic [31:0] cap_awaddr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (a == 32'h3000_0000) return 32'h0000_0413;
    return {a[15:0], ~a[31:16]};
  endfunction

  function automatic logic [1:0] resp_for(input logic [31:0] a, input logic [31:0] err_a);
    return (a == err_a) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  assign arready = !r_busy;
  assign awready = !aw_got;
  assign wready  = !w_got;

  always @(posedge clk) begin
    if (sl_clear) begin
      r_busy <= 1'b0; rvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; b_cnt <= 0;
    end else begin
      if (arvalid && arready) begin
        r_busy <= 1'b1; r_cnt <= sl_lat; r_addr <= araddr;
      end
      if (r_busy && !rvalid) begin
        if (r_cnt <= 1) begin
          rvalid <= 1'b1; rdata <= slave_data(r_addr); rresp <= resp_for(r_addr, sl_err_addr);
        end else begin
          r_cnt <= r_cnt - 1;
        end
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0; r_busy <= 1'b0;
      end
      if (awvalid && awready) begin
        aw_got <= 1'b1; cap_awaddr <= awaddr;
      end
      if (wvalid && wready) begin
        w_got <= 1'b1; cap_wdata <= wdata; cap_wstrb <= wstrb;
      end
      if (aw_got && w_got && !bvalid) begin
        if (b_cnt >= sl_b_lat) begin
          bvalid <= 1'b1; bresp <= resp_for(cap_awaddr, sl_err_addr);
        end else begin
          b_cnt <= b_cnt + 1;
        end
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
      end
    end
  end

  // ---------------- monitor: scoreboard pops and grant invariants ----------------
  always @(negedge clk) begin : monitor
    rd_exp_t re;
    wr_exp_t we;
    bit      eo;
    if (rst) begin
      checks++;
      if (arvalid && (awvalid || wvalid)) begin
        failures++; $display("FAIL slave_ar_aw_overlap: arvalid=%b awvalid=%b wvalid=%b, required no overlap", arvalid, awvalid, wvalid);
      end
      checks++;
      if ((ifu_rvalid || ifu_arready) && dut.state != IFU_RD) begin
        failures++; $display("FAIL ifu_outside_grant: rvalid=%b arready=%b state=%0d", ifu_rvalid, ifu_arready, dut.state);
      end
      checks++;
      if ((lsu_rvalid || lsu_arready) && dut.state != LSU_RD) begin
        failures++; $display("FAIL lsu_rd_outside_grant: rvalid=%b arready=%b state=%0d", lsu_rvalid, lsu_arready, dut.state);
      end
      checks++;
      if ((lsu_bvalid || lsu_awready || lsu_wready || awvalid || wvalid) && dut.state != LSU_WR) begin
        failures++; $display("FAIL lsu_wr_outside_grant: bvalid=%b awvalid=%b wvalid=%b state=%0d", lsu_bvalid, awvalid, wvalid, dut.state);
      end
      checks++;
      if (arvalid && dut.state != IFU_RD && dut.state != LSU_RD) begin
        failures++; $display("FAIL arvalid_outside_read: state=%0d", dut.state);
      end
      if (ifu_rvalid && ifu_rready) begin
        checks++;
        if (ifu_exp_q.size() == 0) begin
          failures++; $display("FAIL ifu_unexpected_r: rdata=%h, required no response", ifu_rdata);
        end else begin
          re = ifu_exp_q.pop_front();
          if (ifu_rdata !== re.data || ifu_rresp !== re.resp) begin
            failures++; $display("FAIL ifu_rdata: got %h/%b, required %h/%b", ifu_rdata, ifu_rresp, re.data, re.resp);
          end
        end
        if (order_q.size() != 0) begin
          eo = order_q.pop_front(); checks++;
          if (eo !== 1'b0) begin
            failures++; $display("FAIL grant_order: got IFU, required LSU");
          end
        end
      end
      if (lsu_rvalid && lsu_rready) begin
        checks++;
        if (lsu_exp_q.size() == 0) begin
          failures++; $display("FAIL lsu_unexpected_r: rdata=%h, required no response", lsu_rdata);
        end else begin
          re = lsu_exp_q.pop_front();
          if (lsu_rdata !== re.data || lsu_rresp !== re.resp) begin
            failures++; $display("FAIL lsu_rdata: got %h/%b, required %h/%b", lsu_rdata, lsu_rresp, re.data, re.resp);
          end
        end
        if (order_q.size() != 0) begin
          eo = order_q.pop_front(); checks++;
          if (eo !== 1'b1) begin
            failures++; $display("FAIL grant_order: got LSU read, required IFU");
          end
        end
      end
      if (lsu_bvalid && lsu_bready) begin
        checks++;
        if (wr_exp_q.size() == 0) begin
          failures++; $display("FAIL lsu_unexpected_b: bresp=%b, required no response", lsu_bresp);
        end else begin
          we = wr_exp_q.pop_front();
          if (cap_awaddr !== we.addr || cap_wdata !== we.data || cap_wstrb !== we.strb || lsu_bresp !== we.resp) begin
            failures++;
            $display("FAIL lsu_write: got addr=%h data=%h strb=%b bresp=%b, required %h %h %b %b",
                     cap_awaddr, cap_wdata, cap_wstrb, lsu_bresp, we.addr, we.data, we.strb, we.resp);
          end
        end
        if (order_q.size() != 0) begin
          eo = order_q.pop_front(); checks++;
          if (eo !== 1'b1) begin
            failures++; $display("FAIL grant_order: got LSU write, required IFU");
          end
        end
      end
    end
  end

  // ---------------- master drivers ----------------
  task automatic apply_reset();
    rst = 1'b0; sl_clear = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; sl_clear = 1'b0;
  endtask

  task automatic ifu_read(input logic [31:0] addr);
    int n;
    ifu_exp_q.push_back('{data: slave_data(addr), resp: resp_for(addr, sl_err_addr)});
    ifu_araddr = addr; ifu_arvalid = 1'b1; ifu_rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ifu_arready && n < BUDGET);
    if (!ifu_arready) begin
      checks++; failures++; $display("FAIL ifu_ar_timeout: arready=0, required 1 within %0d cycles", BUDGET);
      ifu_arvalid = 1'b0; return;
    end
    @(posedge clk); #1 ifu_arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ifu_rvalid && n < BUDGET);
    if (!ifu_rvalid) begin
      checks++; failures++; $display("FAIL ifu_r_timeout: rvalid=0, required 1 within %0d cycles", BUDGET);
    end
    @(posedge clk); #1 ifu_rready = 1'b0;
  endtask

  task automatic lsu_read(input logic [31:0] addr);
    int n;
    lsu_exp_q.push_back('{data: slave_data(addr), resp: resp_for(addr, sl_err_addr)});
    lsu_araddr = addr; lsu_arvalid = 1'b1; lsu_rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!lsu_arready && n < BUDGET);
    if (!lsu_arready) begin
      checks++; failures++; $display("FAIL lsu_ar_timeout: arready=0, required 1 within %0d cycles", BUDGET);
      lsu_arvalid = 1'b0; return;
    end
    @(posedge clk); #1 lsu_arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!lsu_rvalid && n < BUDGET);
    if (!lsu_rvalid) begin
      checks++; failures++; $display("FAIL lsu_r_timeout: rvalid=0, required 1 within %0d cycles", BUDGET);
    end
    @(posedge clk); #1 lsu_rready = 1'b0;
  endtask

  task automatic lsu_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_delay, input int aw_delay);
    int n;
    wr_exp_q.push_back('{addr: addr, data: data, strb: strb, resp: resp_for(addr, sl_err_addr)});
    lsu_bready = 1'b1;
    fork
      begin
        int k;
        repeat (w_delay) @(posedge clk);
        #1 lsu_wdata = data; lsu_wstrb = strb; lsu_wvalid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!lsu_wready && k < BUDGET);
        if (!lsu_wready) begin
          checks++; failures++; $display("FAIL lsu_w_timeout: wready=0, required 1 within %0d cycles", BUDGET);
        end
        @(posedge clk); #1 lsu_wvalid = 1'b0;
      end
      begin
        int k;
        repeat (aw_delay) @(posedge clk);
        #1 lsu_awaddr = addr; lsu_awvalid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!lsu_awready && k < BUDGET);
        if (!lsu_awready) begin
          checks++; failures++; $display("FAIL lsu_aw_timeout: awready=0, required 1 within %0d cycles", BUDGET);
        end
        @(posedge clk); #1 lsu_awvalid = 1'b0;
      end
    join
    n = 0;
    while (!lsu_bvalid && n < BUDGET) begin @(negedge clk); n++; end
    if (!lsu_bvalid) begin
      checks++; failures++; $display("FAIL lsu_b_timeout: bvalid=0, required 1 within %0d cycles", BUDGET);
    end
    @(posedge clk); #1 lsu_bready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid,
         arvalid, rready, awvalid, wvalid, bready} !== 12'b0) begin
      failures++; $display("FAIL reset_outputs: valid/ready vector nonzero, required all 0");
    end
    checks++;
    if (dut.state !== IDLE) begin
      failures++; $display("FAIL reset_state: got %0d, required IDLE", dut.state);
    end
  endtask

  task automatic test_ifu_only();
    sl_lat = 3;
    ifu_read(32'h3000_0000);
    @(negedge clk);
    checks++;
    if (dut.state !== IDLE || ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0) begin
      failures++; $display("FAIL ifu_only_end: state=%0d ifu_rvalid=%b lsu_rvalid=%b, required IDLE/0/0",
                           dut.state, ifu_rvalid, lsu_rvalid);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    order_q = '{1'b1, 1'b0, 1'b1, 1'b0};
    fork
      begin ifu_read(32'h3000_0004); ifu_read(32'h3000_0008); end
      begin lsu_read(32'h0f00_0010); lsu_read(32'h0f00_0014); end
    join
    checks++;
    if (order_q.size() != 0) begin
      failures++; $display("FAIL rr_incomplete: %0d completions missing, required 0", order_q.size());
    end
  endtask

  task automatic test_write_w_first();
    lsu_write(32'h1000_0000, 32'h0000_0041, 4'b0001, 1, 3);
    @(negedge clk);
    checks++;
    if (dut.state !== IDLE || lsu_bvalid !== 1'b0) begin
      failures++; $display("FAIL write_end: state=%0d bvalid=%b, required IDLE/0", dut.state, lsu_bvalid);
    end
  endtask

  task automatic test_write_vs_read();
    apply_reset();
    order_q = '{1'b1, 1'b0};
    fork
      ifu_read(32'h3000_000c);
      lsu_write(32'h1000_0004, 32'hdead_beef, 4'hf, 0, 0);
    join
    checks++;
    if (order_q.size() != 0) begin
      failures++; $display("FAIL wr_rd_incomplete: %0d completions missing, required 0", order_q.size());
    end
  endtask

  task automatic test_error_resp();
    sl_err_addr = 32'h0f00_0020;
    order_q = '{1'b1, 1'b0};
    fork
      lsu_read(32'h0f00_0020);
      begin @(posedge clk); #1 ifu_read(32'h3000_0010); end
    join
    checks++;
    if (order_q.size() != 0 || dut.state !== IDLE) begin
      failures++; $display("FAIL err_then_ifu: pending=%0d state=%0d, required 0/IDLE", order_q.size(), dut.state);
    end
    sl_err_addr = 32'hffff_fff0;
  endtask

  task automatic test_reset_mid_write();
    int n;
    sl_b_lat = 6;
    lsu_awaddr = 32'h1000_0008; lsu_wdata = 32'h5555_aaaa; lsu_wstrb = 4'hf;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(lsu_awready && lsu_wready) && n < BUDGET);
    checks++;
    if (!(lsu_awready && lsu_wready)) begin
      failures++; $display("FAIL midwr_accept: awready=%b wready=%b, required 1/1", lsu_awready, lsu_wready);
    end
    @(posedge clk); #1 lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; lsu_bready = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.state !== LSU_WR) begin
      failures++; $display("FAIL midwr_state: got %0d, required LSU_WR", dut.state);
    end
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.state !== IDLE || awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0) begin
      failures++; $display("FAIL midwr_after_reset: state=%0d awvalid=%b wvalid=%b bready=%b, required IDLE/0/0/0",
                           dut.state, awvalid, wvalid, bready);
    end
    n = 0;
    while (!bvalid && n < BUDGET) begin @(negedge clk); n++; end
    checks++;
    if (!bvalid || lsu_bvalid !== 1'b0 || bready !== 1'b0) begin
      failures++; $display("FAIL stale_bvalid: slave bvalid=%b lsu_bvalid=%b bready=%b, required 1/0/0",
                           bvalid, lsu_bvalid, bready);
    end
    @(posedge clk); #1 sl_clear = 1'b1; lsu_bready = 1'b0; sl_b_lat = 1;
    @(posedge clk); #1 sl_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ifu_only();
    test_round_robin();
    test_write_w_first();
    test_write_vs_read();
    test_error_resp();
    test_reset_mid_write();
    repeat (2) @(posedge clk);
    checks++;
    if (ifu_exp_q.size() != 0 || lsu_exp_q.size() != 0 || wr_exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: ifu=%0d lsu=%0d wr=%0d left, required 0",
                           ifu_exp_q.size(), lsu_exp_q.size(), wr_exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_25040129_axi_arbiter.md
YSYX_25040129_AXI_ARBITER -- requirements
Module: ysyx_25040129_axi_arbiter

Interface
REQ-001 The block SHALL have parameter LSU_FIRST, default 1: on a simultaneous first request, 1 grants the LSU and 0 grants the IFU.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low (asserted when 0).
REQ-004 The block SHALL have IFU read-address ports ifu_araddr in 32, ifu_arvalid in 1, ifu_arready out 1, ifu_arsize in 3.
REQ-005 The block SHALL have IFU read-data ports ifu_rdata out 32, ifu_rresp out 2, ifu_rvalid out 1, ifu_rready in 1.
REQ-006 The block SHALL have LSU read ports lsu_araddr in 32, lsu_arvalid in 1, lsu_arready out 1, lsu_arsize in 3, lsu_rdata out 32, lsu_rresp out 2, lsu_rvalid out 1, lsu_rready in 1.
REQ-007 The block SHALL have LSU write ports lsu_awaddr in 32, lsu_awvalid in 1, lsu_awready out 1, lsu_wdata in 32, lsu_wstrb in 4, lsu_wvalid in 1, lsu_wready out 1, lsu_bresp out 2, lsu_bvalid out 1, lsu_bready in 1.
REQ-008 The block SHALL have a slave side mirroring the LSU set: araddr, arvalid, arready, arsize, rdata, rresp, rvalid, rready, awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, with directions reversed and identical widths.

Function
REQ-009 The block SHALL use FSM states IDLE, IFU_RD, LSU_RD and LSU_WR, with the grant held only in the registered state.
REQ-010 In IDLE, the block SHALL drive every slave valid/ready and every master ready/valid to 0, so arbitration costs exactly one cycle.
REQ-011 In IDLE with lsu_awvalid|lsu_wvalid, the next state SHALL be LSU_WR; otherwise with lsu_arvalid it SHALL be LSU_RD; otherwise with ifu_arvalid it SHALL be IFU_RD.
REQ-012 When IFU and LSU requests are simultaneous, the first grant SHALL follow LSU_FIRST; after that, the master not served last SHALL win (round-robin via a 1-bit last_owner register).
REQ-013 In IFU_RD/LSU_RD, the owner's AR and R channels SHALL connect combinationally to the slave, and the non-owner's arready and rvalid SHALL be 0.
REQ-014 The R channel SHALL be routed only to the owner; rdata and rresp SHALL be driven to both masters and qualified by rvalid.
REQ-015 In LSU_WR, the AW, W and B channels SHALL pass through combinationally, with AW and W completing independently in either order.
REQ-016 A read transaction SHALL end on rvalid&&rready and a write on bvalid&&bready; the state SHALL then return to IDLE and last_owner SHALL update.
REQ-017 A non-OKAY rresp or bresp SHALL be forwarded unchanged and SHALL end the transaction like OKAY.
REQ-018 Only one outstanding transaction SHALL exist; a request arriving during a grant SHALL wait, and the master SHALL hold its valid until accepted.
REQ-019 The slave arvalid SHALL never be asserted in LSU_WR, and the slave awvalid/wvalid SHALL never be asserted in either read state.

Reset
REQ-020 While rst==0 at a clock edge, the state SHALL become IDLE and last_owner SHALL become the value that makes LSU_FIRST apply next.
REQ-021 Reset mid-transaction SHALL abandon the transaction; all valid/ready outputs SHALL be 0 in the first cycle after reset releases.
REQ-022 No output SHALL depend on an uninitialised register.

Structure
REQ-023 State encodings and the OKAY response constant (2'b00) SHALL live in the shared ysyx_25040129 defines/package with the existing MEM_READ/MEM_WRITE constants.
REQ-024 The block SHALL be one module without sub-modules; the LSU_RD/IFU_RD mux SHALL be one always @(*) block.

Verification
REQ-025 IFU-only read: ifu_araddr=0x3000_0000, arvalid=1, slave arready=1, rvalid after 3 cycles with rdata=0x00000413 -> ifu_rvalid=1 with that data, IDLE next cycle, lsu_rvalid=0 throughout.
REQ-026 Simultaneous start after reset, LSU_FIRST=1: IFU read 0x3000_0004 and LSU read 0x0f00_0010 -> LSU served first, then IFU; with both still requesting, the round-robin alternates LSU, IFU, LSU.
REQ-027 LSU write with W before AW: wvalid in cycle 1, awvalid in cycle 3, awaddr=0x1000_0000, wstrb=4'b0001, wdata=0x41 -> slave sees both; lsu_bvalid forwarded; IDLE after bready.
REQ-028 Error response: slave rresp=2'b10 on an LSU read -> lsu_rresp=2'b10, transaction ends, and a pending IFU request is granted next.
REQ-029 Reset mid-write: rst=0 while in LSU_WR waiting on bvalid -> state IDLE, awvalid=wvalid=bready=0 on the next cycle, and the stale bvalid is not forwarded.
REQ-030 An assertion SHALL fail if the slave arvalid and awvalid are high in the same cycle or if any master sees a valid outside its grant.
